red_pitaya_pwm_ramp: RTL and testbench

RED_PITAYA_PWM_RAMP -- requirements
Module: red_pitaya_pwm_ramp

---
 rtl/red_pitaya_pwm_ramp.sv | 118 +++++++++++
 tb/tb_red_pitaya_pwm_ramp.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_pwm_ramp.sv
// Slew-limited PWM set-point ramp: moves an 8.4 fixed-point duty toward a target once per PWM frame.
// Define PWM_RAMP_DITHER_EN to drive the fractional dither pattern on cfg[15:0].
module red_pitaya_pwm_ramp #(
  parameter logic [7:0] FULL = 8'd156,
  parameter int         CCW  = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [11:0]    set_val,
  input  logic           set_we,
  input  logic [11:0]    step,
  input  logic           pwm_s,
  output logic [CCW-1:0] cfg,
  output logic           busy,
  output logic           done
);

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [11:0] r_tgt;
  logic [11:0] r_cur;
  logic [11:0] w_cur_next;
  logic [11:0] w_tgt_next;
  logic [11:0] w_lim;
  logic [11:0] w_clamp;
  logic [12:0] w_diff;
  logic [12:0] w_sum;
  logic        w_up;
  logic        w_frame;
  logic        w_finish;
  logic        w_done_next;
  logic [23:0] w_cfg_next;

`ifdef PWM_RAMP_DITHER_EN
  // Bit i is set where floor(i*f/16) steps up, spreading f ones evenly over 16 slots.
  function automatic logic [15:0] f_pat(input logic [3:0] f);
    logic [15:0] p;
    logic [7:0]  a;
    logic [7:0]  b;
    p = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      a    = 8'(i + 1) * {4'd0, f};
      b    = 8'(i) * {4'd0, f};
      p[i] = (a[7:4] != b[7:4]);
    end
    return p;
  endfunction
`endif

  assign w_lim   = {FULL, 4'h0};
  assign w_clamp = (set_val > w_lim) ? w_lim : set_val;

  always_comb begin
    w_up        = (r_tgt > r_cur);
    w_diff      = w_up ? ({1'b0, r_tgt} - {1'b0, r_cur}) : ({1'b0, r_cur} - {1'b0, r_tgt});
    w_sum       = w_up ? ({1'b0, r_cur} + {1'b0, step}) : ({1'b0, r_cur} - {1'b0, step});
    w_frame     = pwm_s && (r_state == RAMP);
    w_finish    = w_frame && ((step == 12'd0) || (w_diff <= {1'b0, step}));
    w_cur_next  = r_cur;
    w_tgt_next  = r_tgt;
    w_state_next = r_state;
    w_done_next = 1'b0;
    if (w_finish) begin
      w_cur_next   = r_tgt;
      w_state_next = IDLE;
      w_done_next  = 1'b1;
    end else if (w_frame) begin
      w_cur_next = w_sum[11:0];
    end else begin
      w_cur_next = r_cur;
    end
    // A write overrides the frame's state decision but the step itself used the old target.
    if (set_we) begin
      w_tgt_next   = w_clamp;
      w_state_next = (w_clamp != w_cur_next) ? RAMP : IDLE;
      w_done_next  = 1'b0;
    end else begin
      w_tgt_next = r_tgt;
    end
`ifdef PWM_RAMP_DITHER_EN
    w_cfg_next = {w_cur_next[11:4], f_pat(w_cur_next[3:0])};
`else
    w_cfg_next = {w_cur_next[11:4], 16'h0000};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tgt <= 12'd0;
      r_cur <= 12'd0;
      cfg   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      r_tgt <= w_tgt_next;
      busy  <= (w_state_next == RAMP);
      done  <= w_done_next;
      if (w_frame) begin
        r_cur <= w_cur_next;
        cfg   <= CCW'(w_cfg_next);
      end
    end
  end

endmodule

// File: tb/tb_red_pitaya_pwm_ramp.sv
// Directed bench for red_pitaya_pwm_ramp; expectations follow PWM_RAMP_DITHER_EN if defined.
module tb_red_pitaya_pwm_ramp;

  logic        clk;
  logic        rst;
  logic [11:0] set_val;
  logic        set_we;
  logic [11:0] step;
  logic        pwm_s;
  logic [23:0] cfg;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

`ifdef PWM_RAMP_DITHER_EN
  localparam logic [15:0] PAT5 = 16'h9248;
  localparam bit          DITH = 1'b1;
`else
  localparam logic [15:0] PAT5 = 16'h0000;
  localparam bit          DITH = 1'b0;
`endif

  red_pitaya_pwm_ramp dut (
    .clk(clk), .rst(rst), .set_val(set_val), .set_we(set_we),
    .step(step), .pwm_s(pwm_s), .cfg(cfg), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_set(input logic [11:0] v);
    @(negedge clk);
    set_val = v;
    set_we  = 1'b1;
    @(negedge clk);
    set_we  = 1'b0;
  endtask

  task automatic frame();
    @(negedge clk);
    pwm_s = 1'b1;
    @(negedge clk);
    pwm_s = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; set_val = 12'd0; set_we = 1'b0; step = 12'd0; pwm_s = 1'b0;
    #12;
    check("reset_cfg", 32'(cfg), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // write equal to cur: no ramp, no done
    write_set(12'h000);
    check("eq_busy", 32'(busy), 32'h0);
    frame();
    check("eq_done", 32'(done), 32'h0);
    check("eq_cfg", 32'(cfg), 32'h0);

    // ramp up 0 -> 3 in steps of 1.0
    step = 12'h010;
    write_set(12'h030);
    check("up_busy0", 32'(busy), 32'h1);
    for (int k = 1; k <= 3; k++) begin
      frame();
      check("up_cfg", 32'(cfg), 32'(k) << 16);
      check("up_done", 32'(done), (k == 3) ? 32'h1 : 32'h0);
      check("up_busy", 32'(busy), (k == 3) ? 32'h0 : 32'h1);
    end
    @(negedge clk);
    check("up_done_pulse", 32'(done), 32'h0);

    // retarget up to 8, then coincident write of 0 on a frame
    write_set(12'h080);
    frame();
    check("rt_cfg4", 32'(cfg), 32'h040000);
    frame();
    check("rt_cfg5", 32'(cfg), 32'h050000);
    @(negedge clk);
    pwm_s = 1'b1; set_we = 1'b1; set_val = 12'h000;
    @(negedge clk);
    pwm_s = 1'b0; set_we = 1'b0;
    check("co_cfg6", 32'(cfg), 32'h060000);
    check("co_busy", 32'(busy), 32'h1);
    check("co_done", 32'(done), 32'h0);
    for (int k = 5; k >= 0; k--) begin
      frame();
      check("dn_cfg", 32'(cfg), 32'(k) << 16);
      check("dn_done", 32'(done), (k == 0) ? 32'h1 : 32'h0);
    end

    // immediate jump
    step = 12'h000;
    write_set(12'h505);
    check("jmp_busy", 32'(busy), 32'h1);
    frame();
    check("jmp_cfg", 32'(cfg), {8'h00, 8'h50, PAT5});
    check("jmp_done", 32'(done), 32'h1);
    check("jmp_busy_after", 32'(busy), 32'h0);
    @(negedge clk);
    check("jmp_done_pulse", 32'(done), 32'h0);

    // clamp to FULL
    write_set(12'hFFF);
    frame();
    check("clamp_cfg", 32'(cfg), 32'h9C0000);

    // fractional pattern popcount
    for (int f = 0; f < 16; f++) begin
      write_set(12'h010 + 12'(f));
      frame();
      check("pat_int", 32'(cfg[23:16]), 32'h1);
      check("pat_pop", 32'($countones(cfg[15:0])), DITH ? 32'(f) : 32'h0);
    end

    // reset mid-ramp (cur currently 0x01F)
    step = 12'h010;
    write_set(12'h800);
    frame();
    check("rst_pre_cfg", 32'(cfg[23:16]), 32'h2);
    check("rst_pre_busy", 32'(busy), 32'h1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_cfg", 32'(cfg), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    frame();
    frame();
    check("post_cfg", 32'(cfg), 32'h0);
    check("post_done", 32'(done), 32'h0);
    check("post_busy", 32'(busy), 32'h0);
    write_set(12'h020);
    frame();
    check("post_ramp_cfg", 32'(cfg), 32'h010000);
    check("post_ramp_busy", 32'(busy), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
